// File: rtl/uart_rx_os16.sv
// UART receiver driven by a 16x oversampling strobe: start-bit validation,
// 3-sample majority vote per bit, LSB-first deframing with optional parity.
module uart_rx_os16 #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick_16x,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK_WAIT
  } state_t;

  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);
  localparam logic       PAR_ON   = (PARITY_EN != 0);
  localparam logic       PAR_ODD  = (PARITY_ODD != 0);

  state_t               state_q;
  logic                 rx_meta_q;
  logic                 rx_s_q;
  logic [3:0]           tick_cnt_q;
  logic [3:0]           bit_idx_q;
  logic                 samp7_q;
  logic                 samp8_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_mis_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 frame_err_q;
  logic                 parity_err_q;
  logic                 busy_q;

  logic maj;
  logic at_mid;
  logic at_end;

  // Third sample is the live synchronized line at tick 9.
  assign maj    = (samp7_q & samp8_q) | (samp7_q & rx_s_q) | (samp8_q & rx_s_q);
  assign at_mid = (tick_cnt_q == 4'd9);
  assign at_end = (tick_cnt_q == 4'd15);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      tick_cnt_q   <= '0;
      bit_idx_q    <= '0;
      samp7_q      <= 1'b0;
      samp8_q      <= 1'b0;
      shift_q      <= '0;
      par_mis_q    <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_s_q     <= rx_meta_q;
      rx_valid_q <= 1'b0;

      if (baud_tick_16x) begin
        if (state_q != S_IDLE) tick_cnt_q <= tick_cnt_q + 4'd1;
        if (tick_cnt_q == 4'd7) samp7_q <= rx_s_q;
        if (tick_cnt_q == 4'd8) samp8_q <= rx_s_q;

        case (state_q)
          S_IDLE: begin
            // The detecting tick is tick 0, so the next tick is tick 1.
            if (!rx_s_q) begin
              state_q    <= S_START;
              busy_q     <= 1'b1;
              tick_cnt_q <= 4'd1;
              par_mis_q  <= 1'b0;
            end
          end

          S_START: begin
            if (at_mid && maj) begin
              state_q    <= S_IDLE;
              busy_q     <= 1'b0;
              tick_cnt_q <= '0;
            end else if (at_end) begin
              state_q   <= S_DATA;
              bit_idx_q <= '0;
            end
          end

          S_DATA: begin
            if (at_mid) shift_q <= {maj, shift_q[DATA_BITS-1:1]};
            if (at_end) begin
              if (bit_idx_q == LAST_BIT) begin
                state_q <= PAR_ON ? S_PARITY : S_STOP;
              end else begin
                bit_idx_q <= bit_idx_q + 4'd1;
              end
            end
          end

          S_PARITY: begin
            if (at_mid) par_mis_q <= (^shift_q) ^ maj ^ PAR_ODD;
            if (at_end) state_q <= S_STOP;
          end

          S_STOP: begin
            // Leaving at mid-stop tolerates early start edges of the next frame.
            if (at_mid) begin
              rx_data_q    <= shift_q;
              frame_err_q  <= ~maj;
              parity_err_q <= PAR_ON & par_mis_q;
              rx_valid_q   <= 1'b1;
              tick_cnt_q   <= '0;
              state_q      <= maj ? S_IDLE : S_BREAK_WAIT;
              busy_q       <= ~maj;
            end
          end

          S_BREAK_WAIT: begin
            if (rx_s_q) begin
              state_q    <= S_IDLE;
              busy_q     <= 1'b0;
              tick_cnt_q <= '0;
            end
          end

          default: begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            tick_cnt_q <= '0;
          end
        endcase
      end
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_os16.sv
// Bench for uart_rx_os16: an 8N1 instance (A) and an 8E1 instance (B) fed
// scripted and random frames, checked against a frame-level reference model.
module tb_uart_rx_os16;

  localparam int PARITY_ODD_B = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_tick_16x = 1'b0;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;
  logic [7:0] rx_data_a, rx_data_b;
  logic       rx_valid_a, rx_valid_b;
  logic       frame_err_a, frame_err_b;
  logic       parity_err_a, parity_err_b;
  logic       busy_a, busy_b;

  int n_checks = 0;
  int n_pass = 0;

  // Each captured pulse: {busy, frame_err, parity_err, data}
  logic [10:0] qa[$];
  logic [10:0] qb[$];
  bit prev_a = 0, prev_b = 0;
  int dbl_a = 0, dbl_b = 0;

  uart_rx_os16 #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .baud_tick_16x(baud_tick_16x), .rx(rx_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .frame_err(frame_err_a),
    .parity_err(parity_err_a), .busy(busy_a)
  );

  uart_rx_os16 #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(PARITY_ODD_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .baud_tick_16x(baud_tick_16x), .rx(rx_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .frame_err(frame_err_b),
    .parity_err(parity_err_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  // One-clk tick every 4 clks.
  initial begin
    forever begin
      repeat (3) @(negedge clk);
      baud_tick_16x = 1'b1;
      @(negedge clk);
      baud_tick_16x = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rx_valid_a) begin
      qa.push_back({busy_a, frame_err_a, parity_err_a, rx_data_a});
      if (prev_a) dbl_a++;
    end
    if (rx_valid_b) begin
      qb.push_back({busy_b, frame_err_b, parity_err_b, rx_data_b});
      if (prev_b) dbl_b++;
    end
    prev_a = rx_valid_a;
    prev_b = rx_valid_b;
  end

  // Expected capture for a frame: busy stays high only if the stop bit was low.
  function automatic logic [10:0] model(input logic [7:0] d, input bit has_par,
                                        input bit par, input bit stop_v);
    bit perr;
    perr = has_par ? (((($countones(d) + int'(par)) % 2) != PARITY_ODD_B)) : 1'b0;
    return {!stop_v, !stop_v, perr, d};
  endfunction

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!baud_tick_16x) @(posedge clk);
    end
    #1;
  endtask

  task automatic drive(input int dut, input bit v, input int ticks);
    if (dut == 0) rx_a = v;
    else rx_b = v;
    wait_ticks(ticks);
  endtask

  // glitch_bit selects a line bit (0 = start) that gets a 1-tick inversion mid-bit.
  task automatic send_frame(input int dut, input logic [7:0] d, input bit has_par,
                            input bit par, input bit stop_v, input int stop_ticks,
                            input int glitch_bit);
    bit bits[$];
    bits.push_back(1'b0);
    for (int k = 0; k < 8; k++) bits.push_back(d[k]);
    if (has_par) bits.push_back(par);
    for (int i = 0; i < bits.size(); i++) begin
      if (i == glitch_bit) begin
        drive(dut, bits[i], 8);
        drive(dut, !bits[i], 1);
        drive(dut, bits[i], 7);
      end else begin
        drive(dut, bits[i], 16);
      end
    end
    drive(dut, stop_v, stop_ticks);
  endtask

  task automatic test_reset;
    logic [11:0] got;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    got = {rx_data_a, rx_valid_a, frame_err_a, parity_err_a, busy_a};
    n_checks++;
    if (got !== 12'h000) $display("FAIL reset_a: got %h expected 000", got);
    else n_pass++;
    got = {rx_data_b, rx_valid_b, frame_err_b, parity_err_b, busy_b};
    n_checks++;
    if (got !== 12'h000) $display("FAIL reset_b: got %h expected 000", got);
    else n_pass++;
    rst_n = 1'b1;
    wait_ticks(4);
  endtask

  task automatic test_basic;
    logic [10:0] got, exp;
    qa.delete();
    send_frame(0, 8'hA5, 0, 0, 1, 16, -1);
    wait_ticks(4);
    n_checks++;
    if (qa.size() !== 1) $display("FAIL basic_count: got %0d expected 1", qa.size());
    else n_pass++;
    if (qa.size() > 0) begin
      got = qa.pop_front();
      exp = model(8'hA5, 0, 0, 1);
      n_checks++;
      if (got !== exp) $display("FAIL basic_a5: got %h expected %h", got, exp);
      else n_pass++;
    end
    n_checks++;
    if (busy_a !== 1'b0) $display("FAIL basic_busy: got %b expected 0", busy_a);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [10:0] got, exp;
    qa.delete();
    send_frame(0, 8'h00, 0, 0, 1, 10, -1);
    send_frame(0, 8'hFF, 0, 0, 1, 10, -1);
    wait_ticks(6);
    n_checks++;
    if (qa.size() !== 2) $display("FAIL b2b_count: got %0d expected 2", qa.size());
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      if (qa.size() > 0) begin
        got = qa.pop_front();
        exp = model((i == 0) ? 8'h00 : 8'hFF, 0, 0, 1);
        n_checks++;
        if (got !== exp) $display("FAIL b2b_%0d: got %h expected %h", i, got, exp);
        else n_pass++;
      end
    end
  endtask

  task automatic test_false_start;
    qa.delete();
    drive(0, 1'b0, 5);
    drive(0, 1'b1, 30);
    n_checks++;
    if (qa.size() !== 0) $display("FAIL glitch_count: got %0d expected 0", qa.size());
    else n_pass++;
    n_checks++;
    if ({busy_a, rx_data_a} !== {1'b0, 8'hFF})
      $display("FAIL glitch_state: got %h expected 0ff", {busy_a, rx_data_a});
    else n_pass++;
  endtask

  task automatic test_break;
    logic [10:0] got, exp;
    qa.delete();
    send_frame(0, 8'h3C, 0, 0, 0, 32, -1);
    n_checks++;
    if (qa.size() !== 1) $display("FAIL break_count: got %0d expected 1", qa.size());
    else n_pass++;
    if (qa.size() > 0) begin
      got = qa.pop_front();
      exp = model(8'h3C, 0, 0, 0);
      n_checks++;
      if (got !== exp) $display("FAIL break_frame: got %h expected %h", got, exp);
      else n_pass++;
    end
    n_checks++;
    if (busy_a !== 1'b1) $display("FAIL break_busy: got %b expected 1", busy_a);
    else n_pass++;
    drive(0, 1'b1, 8);
    send_frame(0, 8'h55, 0, 0, 1, 16, -1);
    wait_ticks(4);
    n_checks++;
    if (qa.size() !== 1) $display("FAIL break_next_count: got %0d expected 1", qa.size());
    else n_pass++;
    if (qa.size() > 0) begin
      got = qa.pop_front();
      exp = model(8'h55, 0, 0, 1);
      n_checks++;
      if (got !== exp) $display("FAIL break_next: got %h expected %h", got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_parity;
    logic [10:0] got, exp;
    for (int p = 0; p < 2; p++) begin
      qb.delete();
      send_frame(1, 8'h07, 1, p[0], 1, 16, -1);
      wait_ticks(4);
      exp = model(8'h07, 1, p[0], 1);
      n_checks++;
      if (qb.size() !== 1) $display("FAIL parity_count_%0d: got %0d expected 1", p, qb.size());
      else n_pass++;
      if (qb.size() > 0) begin
        got = qb.pop_front();
        n_checks++;
        if (got !== exp) $display("FAIL parity_%0d: got %h expected %h", p, got, exp);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0]  d;
    logic [10:0] got, exp;
    logic [11:0] outs;
    d = 8'hC3;
    qa.delete();
    drive(0, 1'b0, 16);
    for (int k = 0; k < 4; k++) drive(0, d[k], 16);
    drive(0, d[4], 8);
    rst_n = 1'b0;
    @(negedge clk);
    outs = {rx_data_a, rx_valid_a, frame_err_a, parity_err_a, busy_a};
    n_checks++;
    if (outs !== 12'h000) $display("FAIL midrst_outs: got %h expected 000", outs);
    else n_pass++;
    rx_a = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(40);
    n_checks++;
    if (qa.size() !== 0) $display("FAIL midrst_count: got %0d expected 0", qa.size());
    else n_pass++;
    send_frame(0, 8'h81, 0, 0, 1, 16, -1);
    wait_ticks(4);
    exp = model(8'h81, 0, 0, 1);
    n_checks++;
    if (qa.size() !== 1) $display("FAIL midrst_next_count: got %0d expected 1", qa.size());
    else n_pass++;
    if (qa.size() > 0) begin
      got = qa.pop_front();
      n_checks++;
      if (got !== exp) $display("FAIL midrst_next: got %h expected %h", got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_random;
    logic [7:0]  d;
    logic [10:0] got, exp;
    bit stop_v, par;
    int stop_len, gl;
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom);
      stop_v = ($urandom_range(0, 4) != 0);
      stop_len = stop_v ? int'($urandom_range(10, 16)) : 16;
      gl = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 8));
      qa.delete();
      send_frame(0, d, 0, 0, stop_v, stop_len, gl);
      exp = model(d, 0, 0, stop_v);
      drive(0, 1'b1, 4);
      n_checks++;
      if (qa.size() !== 1) $display("FAIL rand_a_count_%0d: got %0d expected 1", i, qa.size());
      else n_pass++;
      if (qa.size() > 0) begin
        got = qa.pop_front();
        n_checks++;
        if (got !== exp) $display("FAIL rand_a_%0d: got %h expected %h", i, got, exp);
        else n_pass++;
      end
    end
    for (int i = 0; i < 10; i++) begin
      d = 8'($urandom);
      par = 1'($urandom);
      gl = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 9));
      qb.delete();
      send_frame(1, d, 1, par, 1, 16, gl);
      wait_ticks(4);
      exp = model(d, 1, par, 1);
      n_checks++;
      if (qb.size() !== 1) $display("FAIL rand_b_count_%0d: got %0d expected 1", i, qb.size());
      else n_pass++;
      if (qb.size() > 0) begin
        got = qb.pop_front();
        n_checks++;
        if (got !== exp) $display("FAIL rand_b_%0d: got %h expected %h", i, got, exp);
        else n_pass++;
      end
    end
  endtask

  task automatic test_pulse_width;
    n_checks++;
    if ((dbl_a + dbl_b) !== 0)
      $display("FAIL valid_width: got %0d double pulses expected 0", dbl_a + dbl_b);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_false_start();
    test_break();
    test_parity();
    test_reset_mid_frame();
    test_random();
    test_pulse_width();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
